// File: rtl/snn_input_spike_encoder.sv
// Rate-coding front end: loads a serial pixel frame, then emits
// SPIKE_WINDOW phase-accumulator spike vectors, one every STEP_DIV clocks.
module snn_input_spike_encoder #(
    parameter int INPUT_SIZE   = 64,
    parameter int PIXEL_WIDTH  = 8,
    parameter int SPIKE_WINDOW = 16,
    parameter int STEP_DIV     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            abort,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [PIXEL_WIDTH-1:0]          pix_data,
    output logic [INPUT_SIZE-1:0]           spike_out,
    output logic                            spike_valid,
    output logic [$clog2(SPIKE_WINDOW)-1:0] step_idx,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int CW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = $clog2(SPIKE_WINDOW);

    localparam logic [CW-1:0] CNT_LAST  = CW'(INPUT_SIZE - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(STEP_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(SPIKE_WINDOW - 1);

    typedef enum logic {
        LOAD,
        ENCODE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] count_q;
    logic [DW-1:0] div_q;
    logic [SW-1:0] step_q;

    logic [PIXEL_WIDTH-1:0] pixel_q [INPUT_SIZE];
    logic [PIXEL_WIDTH-1:0] acc_q   [INPUT_SIZE];
    logic [PIXEL_WIDTH:0]   sum     [INPUT_SIZE];

    logic handshake;
    logic load_last;
    logic wrap;
    logic last_step;

    // Abort suppresses both a pixel handshake and a timestep in its cycle.
    assign handshake = pix_valid && pix_ready;
    assign load_last = handshake && (count_q == CNT_LAST);
    assign wrap      = (state_q == ENCODE) && (div_q == DIV_LAST) && !abort;
    assign last_step = wrap && (step_q == STEP_LAST);

    // Per-lane accumulate: carry out of acc+pixel is the lane's spike.
    always_comb begin
        for (int k = 0; k < INPUT_SIZE; k++) begin
            sum[k] = {1'b0, acc_q[k]} + {1'b0, pixel_q[k]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort always returns to LOAD.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD:    if (load_last) state_d = ENCODE;
                ENCODE:  if (last_step) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    // Outputs: spikes are presented only during the divider-wrap cycle.
    always_comb begin
        pix_ready   = (state_q == LOAD) && !abort;
        busy        = (state_q == ENCODE);
        spike_valid = wrap;
        frame_done  = last_step;
        step_idx    = wrap ? step_q : '0;
        spike_out   = '0;
        for (int k = 0; k < INPUT_SIZE; k++) begin
            if (wrap) spike_out[k] = sum[k][PIXEL_WIDTH];
        end
    end

    // Pixel count, clock divider and timestep counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= '0;
            step_q  <= '0;
        end else if (abort) begin
            count_q <= '0;
            div_q   <= '0;
            step_q  <= '0;
        end else if (state_q == LOAD) begin
            if (load_last) begin
                count_q <= '0;
                div_q   <= '0;
                step_q  <= '0;
            end else if (handshake) begin
                count_q <= count_q + CW'(1);
            end
        end else begin
            if (wrap) begin
                div_q  <= '0;
                step_q <= (step_q == STEP_LAST) ? '0 : step_q + SW'(1);
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    // Pixel store; values persist across frames until overwritten.
    always_ff @(posedge clk) begin
        if (handshake) pixel_q[count_q] <= pix_data;
    end

    // Phase accumulators: cleared on frame start, advanced each timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < INPUT_SIZE; k++) acc_q[k] <= '0;
        end else if (load_last) begin
            for (int k = 0; k < INPUT_SIZE; k++) acc_q[k] <= '0;
        end else if (wrap) begin
            for (int k = 0; k < INPUT_SIZE; k++) begin
                acc_q[k] <= sum[k][PIXEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_snn_input_spike_encoder.sv
// Scoreboard bench for snn_input_spike_encoder: drivers push expected
// timesteps, monitors pop and compare on every spike_valid.
module tb_snn_input_spike_encoder;

    localparam int N = 64;
    localparam int W = 16;
    localparam int D = 8;

    typedef struct {
        int          cyc;
        logic [3:0]  step;
        logic [N-1:0] spk;
        logic        done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         abort;
    logic         pix_valid;
    logic         pix_ready;
    logic [7:0]   pix_data;
    logic [N-1:0] spike_out;
    logic         spike_valid;
    logic [3:0]   step_idx;
    logic         frame_done;
    logic         busy;

    logic         b_rst;
    logic         b_abort;
    logic         b_pix_valid;
    logic         b_pix_ready;
    logic [7:0]   b_pix_data;
    logic [N-1:0] b_spike_out;
    logic         b_spike_valid;
    logic [3:0]   b_step_idx;
    logic         b_frame_done;
    logic         b_busy;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   hc;
    int   bhc;
    exp_t q[$];
    exp_t qb[$];
    exp_t em;
    exp_t ebm;
    logic [7:0] px [N];

    snn_input_spike_encoder #(
        .INPUT_SIZE(N), .PIXEL_WIDTH(8), .SPIKE_WINDOW(W), .STEP_DIV(D)
    ) u_dut (
        .clk(clk), .rst(rst), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .spike_out(spike_out), .spike_valid(spike_valid),
        .step_idx(step_idx), .frame_done(frame_done), .busy(busy)
    );

    snn_input_spike_encoder #(
        .INPUT_SIZE(N), .PIXEL_WIDTH(8), .SPIKE_WINDOW(W), .STEP_DIV(1)
    ) u_dut_div1 (
        .clk(clk), .rst(b_rst), .abort(b_abort),
        .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
        .pix_data(b_pix_data),
        .spike_out(b_spike_out), .spike_valid(b_spike_valid),
        .step_idx(b_step_idx), .frame_done(b_frame_done), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Monitor for the STEP_DIV=8 instance.
    always @(negedge clk) begin
        if (spike_valid) begin
            if (q.size() == 0) begin
                chk("unexpected spike_valid", 1, 0);
            end else begin
                em = q.pop_front();
                chk("spike cycle", cyc, em.cyc);
                chk("step_idx", step_idx, em.step);
                chk("spike_out", spike_out, em.spk);
                chk("frame_done", frame_done, em.done);
            end
        end else begin
            chk("idle spike_out", spike_out, 0);
            chk("idle frame_done", frame_done, 0);
        end
    end

    // Monitor for the STEP_DIV=1 instance.
    always @(negedge clk) begin
        if (b_spike_valid) begin
            if (qb.size() == 0) begin
                chk("div1 unexpected spike_valid", 1, 0);
            end else begin
                ebm = qb.pop_front();
                chk("div1 spike cycle", cyc, ebm.cyc);
                chk("div1 step_idx", b_step_idx, ebm.step);
                chk("div1 spike_out", b_spike_out, ebm.spk);
                chk("div1 frame_done", b_frame_done, ebm.done);
            end
        end else begin
            chk("div1 idle spike_out", b_spike_out, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        pix_valid = 1'b0;
        repeat (g) tick();
        pix_valid = 1'b1;
        pix_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pix_ready) begin
                hc = cyc;
                tick();
                pix_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("pix_ready timeout", 0, 1);
        pix_valid = 1'b0;
    endtask

    task automatic load(input int maxgap);
        for (int k = 0; k < N; k++) send(px[k], maxgap);
    endtask

    // Lane k has fired floor(s*p/256) times after s steps; a spike at step s
    // is an increase of that count.
    task automatic push_formula(input int nsteps);
        exp_t e;
        for (int s = 0; s < nsteps; s++) begin
            e.cyc  = hc + D * (s + 1);
            e.step = 4'(s);
            e.done = (s == W - 1);
            for (int k = 0; k < N; k++) begin
                e.spk[k] = (((s + 1) * int'(px[k])) / 256)
                         > ((s * int'(px[k])) / 256);
            end
            q.push_back(e);
        end
    endtask

    task automatic push_one(input int s, input logic [N-1:0] spk);
        exp_t e;
        e.cyc  = hc + D * (s + 1);
        e.step = 4'(s);
        e.done = (s == W - 1);
        e.spk  = spk;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && q.size() > 0; i++) tick();
        chk(name, q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        exp_t eb;
        int   tgt;
        rst = 1'b1;  abort = 1'b0;  pix_valid = 1'b0;  pix_data = '0;
        b_rst = 1'b1; b_abort = 1'b0; b_pix_valid = 1'b0; b_pix_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset spike_out", spike_out, 0);
        chk("reset spike_valid", spike_valid, 0);
        chk("reset step_idx", step_idx, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset busy", busy, 0);
        chk("reset pix_ready", pix_ready, 1);
        tick();
        rst = 1'b0;
        b_rst = 1'b0;
        tick();

        // T6: STEP_DIV=1, all pixels 64 -> lanes fire on steps 3,7,11,15.
        for (int k = 0; k < N; k++) begin
            b_pix_valid = 1'b1;
            b_pix_data  = 8'd64;
            @(negedge clk);
            chk("div1 pix_ready", b_pix_ready, 1);
            if (k == N - 1) bhc = cyc;
            tick();
        end
        b_pix_valid = 1'b0;
        for (int s = 0; s < W; s++) begin
            eb.cyc  = bhc + s + 1;
            eb.step = 4'(s);
            eb.done = (s == W - 1);
            eb.spk  = (s % 4 == 3) ? {N{1'b1}} : '0;
            qb.push_back(eb);
        end
        for (int i = 0; i < 200 && qb.size() > 0; i++) tick();
        chk("div1 drain", qb.size(), 0);
        tick();

        // T1: all 128 -> odd steps all ones, even steps zero.
        for (int k = 0; k < N; k++) px[k] = 8'd128;
        load(0);
        for (int s = 0; s < W; s++) begin
            push_one(s, (s % 2 == 1) ? {N{1'b1}} : '0);
        end
        drain("T1 drain");

        // T2: ramp 4k -> lane k fires k/4 times.
        for (int k = 0; k < N; k++) px[k] = 8'(4 * k);
        load(0);
        push_formula(W);
        drain("T2 drain");

        // T3: single full-scale pixel on lane 5.
        for (int k = 0; k < N; k++) px[k] = 8'd0;
        px[5] = 8'd255;
        load(2);
        for (int s = 0; s < W; s++) begin
            push_one(s, (s > 0) ? (64'd1 << 5) : 64'd0);
        end
        drain("T3 drain");

        // T4: random gaps, pix_valid held high while encoding.
        for (int k = 0; k < N; k++) px[k] = 8'(3 * k + 7);
        load(3);
        push_formula(W);
        pix_valid = 1'b1;
        pix_data  = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("encode ready/busy", {pix_ready, busy}, 2'b01);
            tick();
        end
        pix_valid = 1'b0;
        drain("T4a drain");
        for (int k = 0; k < N; k++) px[k] = 8'(255 - 2 * k);
        load(2);
        push_formula(W);
        drain("T4b drain");

        // T5a: abort on the step-7 wrap cycle.
        for (int k = 0; k < N; k++) px[k] = 8'(4 * k + 1);
        load(0);
        push_formula(7);
        tgt = hc + D * 8;
        for (int i = 0; i < 1000 && cyc != tgt; i++) tick();
        abort = 1'b1;
        @(negedge clk);
        chk("abort spike_valid", spike_valid, 0);
        chk("abort frame_done", frame_done, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("post-abort pix_ready", pix_ready, 1);
        chk("post-abort busy", busy, 0);
        tick();
        repeat (150) tick();
        chk("abort queue", q.size(), 0);

        // Abort beats a same-cycle handshake.
        pix_valid = 1'b1;
        pix_data  = 8'd9;
        abort     = 1'b1;
        @(negedge clk);
        chk("abort blocks pix_ready", pix_ready, 0);
        tick();
        abort     = 1'b0;
        pix_valid = 1'b0;

        // T5b: reset after 30 pixels, next frame starts at lane 0.
        for (int k = 0; k < 30; k++) send(8'd200, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst spike_out", spike_out, 0);
        chk("rst spike_valid", spike_valid, 0);
        chk("rst step_idx", step_idx, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < N; k++) px[k] = 8'd0;
        px[0] = 8'd255;
        load(0);
        for (int s = 0; s < W; s++) begin
            push_one(s, (s > 0) ? 64'd1 : 64'd0);
        end
        drain("T5b drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
